// File: rtl/mem_bus_responder_if.sv
// -----------------------------------------------------------------------------
// mem_bus_responder_if
// Purpose : groups the multiplexed address/data bus, the access strobes, the
//           program-preload side port and the error flag shared by a bus
//           controller and the mem_bus_responder memory.
// Signals : ALE       - address latch enable (controller -> responder)
//           En        - access strobe
//           Rw        - direction, 1 = read, 0 = write
//           Bus_In    - address or write data from the controller (8 bits)
//           Bus_Out   - read data back to the controller (8 bits)
//           Bus_Oe    - Bus_Out valid / drive enable
//           Load_En   - side-port write strobe for preload
//           Load_Addr - side-port address (8 bits)
//           Load_Data - side-port data (8 bits)
//           Wr_Err    - one-cycle pulse after a discarded protected write
// Modports: master (controller side), slave (responder side).
// -----------------------------------------------------------------------------
interface mem_bus_responder_if;
   logic       ALE;
   logic       En;
   logic       Rw;
   logic [7:0] Bus_In;
   logic [7:0] Bus_Out;
   logic       Bus_Oe;
   logic       Load_En;
   logic [7:0] Load_Addr;
   logic [7:0] Load_Data;
   logic       Wr_Err;

   modport master (
      output ALE, En, Rw, Bus_In, Load_En, Load_Addr, Load_Data,
      input  Bus_Out, Bus_Oe, Wr_Err
   );

   modport slave (
      input  ALE, En, Rw, Bus_In, Load_En, Load_Addr, Load_Data,
      output Bus_Out, Bus_Oe, Wr_Err
   );
endinterface

// File: rtl/mem_bus_responder.sv
// -----------------------------------------------------------------------------
// mem_bus_responder
// Purpose : 256x8 memory answering a multiplexed address/data bus. An ALE
//           cycle latches the address; later En cycles read or write that
//           same address (no auto-increment). Read data is registered and
//           driven for HOLD_CYCLES cycles starting the cycle after the
//           En&Rw cycle. A side port (Load_*) writes the array at any time
//           for program preload; a same-cycle bus write to the same address
//           takes priority.
// Config  : macro ROM_PROTECT_EN - when defined, bus writes below PROT_BOUND
//           are discarded and Wr_Err pulses for one cycle afterwards; when
//           undefined every address is writable and Wr_Err is tied 0.
// Params  : PROT_BOUND  - first writable address with protection enabled
//           HOLD_CYCLES - cycles Bus_Oe stays high after a read (1..3)
// Ports   : clk         - clock, all state updates on posedge
//           rst         - asynchronous active-high reset
//           bus         - mem_bus_responder_if.slave bus/handshake bundle
//           dbg_state_o - current FSM state (0 IDLE, 1 ADDR, 2 DRIVE)
// Handshake: the controller presents ALE/En/Rw/Bus_In for one clock; an
//           access is accepted at the posedge only when ALE=0, En=1 and an
//           address is held (state not IDLE). Read data is valid exactly
//           while Bus_Oe=1; Bus_Out reads 8'h00 otherwise.
// -----------------------------------------------------------------------------
module mem_bus_responder #(
   parameter logic [7:0] PROT_BOUND  = 8'h80,
   parameter int         HOLD_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   mem_bus_responder_if.slave     bus,
   output logic [1:0]             dbg_state_o
);

`ifdef ROM_PROTECT_EN
   localparam bit PROTECT_EN = 1'b1;
`else
   localparam bit PROTECT_EN = 1'b0;
`endif

   localparam logic [1:0] HOLD_INIT = 2'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      DRIVE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] rd_q, rd_d;
   logic [1:0] hold_q, hold_d;
   logic       wr_err_q, wr_err_d;

   // Deliberately has no reset: contents survive rst.
   logic [7:0] mem_q [256];

   logic access;
   logic bus_rd;
   logic bus_wr;
   logic wr_blocked;
   logic wr_commit;

   // ALE wins over En in the same cycle; En is meaningless until an address
   // has been latched. Reset forces IDLE asynchronously, which also kills any
   // bus write presented during the reset cycle.
   assign access     = !bus.ALE && bus.En && (state_q != IDLE);
   assign bus_rd     = access && bus.Rw;
   assign bus_wr     = access && !bus.Rw;
   assign wr_blocked = PROTECT_EN && (addr_q < PROT_BOUND);
   assign wr_commit  = bus_wr && !wr_blocked;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rd_d     = rd_q;
      hold_d   = hold_q;
      wr_err_d = 1'b0;
      if (bus.ALE) begin
         state_d = ADDR;
         addr_d  = bus.Bus_In;
         hold_d  = 2'd0;
      end else if (bus_rd) begin
         state_d = DRIVE;
         rd_d    = mem_q[addr_q];
         hold_d  = HOLD_INIT;
      end else if (bus_wr) begin
         state_d  = ADDR;
         hold_d   = 2'd0;
         wr_err_d = wr_blocked;
      end else if (state_q == DRIVE) begin
         // Last hold cycle: fall back to ADDR, address stays valid.
         if (hold_q <= 2'd1) begin
            state_d = ADDR;
            hold_d  = 2'd0;
         end else begin
            hold_d = hold_q - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= 8'h00;
         rd_q     <= 8'h00;
         hold_q   <= 2'd0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         hold_q   <= hold_d;
         wr_err_q <= wr_err_d;
      end
   end

   // Bus write is issued after the load write so it wins on an address clash.
   always_ff @(posedge clk) begin
      if (bus.Load_En) begin
         mem_q[bus.Load_Addr] <= bus.Load_Data;
      end
      if (wr_commit) begin
         mem_q[addr_q] <= bus.Bus_In;
      end
   end

   assign bus.Bus_Oe  = (state_q == DRIVE);
   assign bus.Bus_Out = bus.Bus_Oe ? rd_q : 8'h00;
   assign bus.Wr_Err  = PROTECT_EN ? wr_err_q : 1'b0;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_responder
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model: a 256-entry array, a "have an address" flag, the held
// address, and a count of remaining drive cycles.
// -----------------------------------------------------------------------------
module tb_mem_bus_responder;

   localparam int         HOLD  = 1;
   localparam logic [7:0] BOUND = 8'h80;
`ifdef ROM_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   mem_bus_responder_if bus_if ();

   mem_bus_responder #(
      .PROT_BOUND (BOUND),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_if),
      .dbg_state_o(dbg_state)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [7:0] m_mem [256];
   bit         m_valid;
   logic [7:0] m_addr;
   logic [7:0] m_rd;
   int         m_left;
   bit         m_err;
   logic [7:0] exp_q [$];

   int compared   = 0;
   int mismatched = 0;

   // One clock edge of the specified behaviour, using the inputs as driven.
   task automatic model_edge(input bit ale, input bit en, input bit rw,
                             input logic [7:0] din, input bit lden,
                             input logic [7:0] la, input logic [7:0] ld);
      logic [7:0] old_val;
      bit         do_write;
      do_write = 1'b0;
      m_err    = 1'b0;
      old_val  = m_mem[m_addr];
      if (ale) begin
         m_valid = 1'b1;
         m_addr  = din;
         m_left  = 0;
      end else if (en && m_valid) begin
         if (rw) begin
            m_rd   = old_val;
            m_left = HOLD;
            exp_q.push_back(old_val);
         end else begin
            m_left = 0;
            if (PROT && (m_addr < BOUND)) m_err = 1'b1;
            else                          do_write = 1'b1;
         end
      end else if (m_left > 0) begin
         m_left = m_left - 1;
      end
      if (lden)     m_mem[la]     = ld;
      if (do_write) m_mem[m_addr] = din;
   endtask

   task automatic check_val(input string tag, input logic [7:0] got,
                            input logic [7:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check(input string tag);
      logic       exp_oe;
      logic [7:0] exp_out;
      logic [7:0] e;
      exp_oe  = (m_left > 0);
      exp_out = exp_oe ? m_rd : 8'h00;
      compared++;
      assert (bus_if.Bus_Oe === exp_oe) else begin
         mismatched++;
         $error("FAIL %s Bus_Oe got=%b exp=%b", tag, bus_if.Bus_Oe, exp_oe);
      end
      compared++;
      assert (bus_if.Bus_Out === exp_out) else begin
         mismatched++;
         $error("FAIL %s Bus_Out got=%h exp=%h", tag, bus_if.Bus_Out, exp_out);
      end
      compared++;
      assert (bus_if.Wr_Err === m_err) else begin
         mismatched++;
         $error("FAIL %s Wr_Err got=%b exp=%b", tag, bus_if.Wr_Err, m_err);
      end
      // First drive cycle of a read: retire the scoreboard entry.
      if (m_left == HOLD && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         assert (bus_if.Bus_Out === e) else begin
            mismatched++;
            $error("FAIL %s read_data got=%h exp=%h", tag, bus_if.Bus_Out, e);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input bit ale, input bit en, input bit rw,
                        input logic [7:0] din, input bit lden,
                        input logic [7:0] la, input logic [7:0] ld,
                        input string tag);
      bus_if.ALE       = ale;
      bus_if.En        = en;
      bus_if.Rw        = rw;
      bus_if.Bus_In    = din;
      bus_if.Load_En   = lden;
      bus_if.Load_Addr = la;
      bus_if.Load_Data = ld;
      @(posedge clk);
      model_edge(ale, en, rw, din, lden, la, ld);
      #1;
      check(tag);
   endtask

   task automatic idle(input string tag);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, tag);
   endtask

   task automatic bus_read(input logic [7:0] a, input string tag);
      cycle(1'b1, 1'b0, 1'b1, a, 1'b0, 8'h00, 8'h00, {tag, "_ale"});
      cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, {tag, "_rd"});
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d,
                            input string tag);
      cycle(1'b1, 1'b0, 1'b0, a, 1'b0, 8'h00, 8'h00, {tag, "_ale"});
      cycle(1'b0, 1'b1, 1'b0, d, 1'b0, 8'h00, 8'h00, {tag, "_wr"});
   endtask

   // Asynchronous reset raised mid-cycle with a bus write presented, held
   // across one posedge, released after it.
   task automatic do_reset(input string tag);
      bus_if.ALE     = 1'b0;
      bus_if.En      = 1'b1;
      bus_if.Rw      = 1'b0;
      bus_if.Bus_In  = 8'($urandom);
      bus_if.Load_En = 1'b0;
      rst = 1'b1;
      #1;
      m_valid = 1'b0;
      m_left  = 0;
      m_err   = 1'b0;
      exp_q.delete();
      check({tag, "_async"});
      @(posedge clk);
      #1;
      check({tag, "_held"});
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] addr_tab [7] = '{8'h00, 8'h05, 8'h10, 8'h7F, 8'h80, 8'h90, 8'hFF};
   logic [7:0] saved;
   int         r;
   bit         ale, en, rw, lden;
   logic [7:0] din, la, ld;

   initial begin
      bus_if.ALE       = 1'b0;
      bus_if.En        = 1'b0;
      bus_if.Rw        = 1'b0;
      bus_if.Bus_In    = 8'h00;
      bus_if.Load_En   = 1'b0;
      bus_if.Load_Addr = 8'h00;
      bus_if.Load_Data = 8'h00;
      m_valid = 1'b0;
      m_addr  = 8'h00;
      m_rd    = 8'h00;
      m_left  = 0;
      m_err   = 1'b0;
      rst     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset");
      check_val("reset_state", {6'd0, dbg_state}, 8'h00);
      rst = 1'b0;

      // Preload the whole array through the side port.
      for (int a = 0; a < 256; a++) begin
         cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, a[7:0], 8'($urandom_range(0, 255)),
               "preload");
      end

      // Basic read: preload 0x10 = B3, drive for HOLD cycles, then release.
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 8'hB3, "load_b3");
      bus_read(8'h10, "rd_b3");
      check_val("rd_b3_oe", {7'd0, bus_if.Bus_Oe}, 8'h01);
      check_val("rd_b3_val", bus_if.Bus_Out, 8'hB3);
      idle("rd_b3_release");
      check_val("rd_b3_oe_off", {7'd0, bus_if.Bus_Oe}, 8'h00);

      // Write then read the same latched address (no auto-increment).
      cycle(1'b1, 1'b0, 1'b0, 8'h90, 1'b0, 8'h00, 8'h00, "wr5a_ale");
      cycle(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h00, 8'h00, "wr5a_wr");
      cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, "wr5a_rd");
      check_val("wr5a_val", bus_if.Bus_Out, 8'h5A);
      idle("wr5a_idle");

      // ALE with En in the same cycle: no access in the ALE cycle.
      cycle(1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 8'h00, "ale_en_rd");
      check_val("ale_en_no_oe", {7'd0, bus_if.Bus_Oe}, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, "ale_en_then_rd");
      idle("ale_en_idle");
      saved = m_mem[8'h30];
      cycle(1'b1, 1'b1, 1'b0, 8'h30, 1'b0, 8'h00, 8'h00, "ale_en_wr");
      bus_read(8'h30, "ale_en_wr_chk");
      check_val("ale_en_no_write", bus_if.Bus_Out, saved);
      idle("ale_en_wr_idle");

      // Reset, then En without ALE must be ignored; reset during DRIVE.
      do_reset("rst1");
      cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, "no_ale_rd");
      check_val("no_ale_oe", {7'd0, bus_if.Bus_Oe}, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 8'h00, 8'h00, "no_ale_wr");
      saved = m_mem[8'h40];
      bus_read(8'h40, "drive_then_rst");
      check_val("drive_oe", {7'd0, bus_if.Bus_Oe}, 8'h01);
      do_reset("rst_drive");
      check_val("rst_drive_oe", {7'd0, bus_if.Bus_Oe}, 8'h00);
      bus_read(8'h40, "rst_no_write");
      check_val("rst_no_write_val", bus_if.Bus_Out, saved);
      idle("rst_idle");

      // Protected region behaviour.
      saved = m_mem[8'h05];
      bus_write(8'h05, 8'h77, "prot_wr");
`ifdef ROM_PROTECT_EN
      check_val("prot_err_pulse", {7'd0, bus_if.Wr_Err}, 8'h01);
`else
      check_val("prot_err_zero", {7'd0, bus_if.Wr_Err}, 8'h00);
`endif
      idle("prot_after");
      check_val("prot_err_off", {7'd0, bus_if.Wr_Err}, 8'h00);
      bus_read(8'h05, "prot_rd");
`ifdef ROM_PROTECT_EN
      check_val("prot_unchanged", bus_if.Bus_Out, saved);
`else
      check_val("prot_written", bus_if.Bus_Out, 8'h77);
`endif
      bus_write(8'h80, 8'hC4, "bound_wr");
      check_val("bound_err", {7'd0, bus_if.Wr_Err}, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, "bound_rd");
      check_val("bound_val", bus_if.Bus_Out, 8'hC4);
      idle("bound_idle");

      // Same-cycle side-port and bus write to one address: bus wins.
      cycle(1'b1, 1'b0, 1'b0, 8'h90, 1'b0, 8'h00, 8'h00, "clash_ale");
      cycle(1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 8'h90, 8'h11, "clash_wr");
      cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, "clash_rd");
      check_val("clash_val", bus_if.Bus_Out, 8'h22);
      idle("clash_idle");

      // Top address behaves normally.
      bus_write(8'hFF, 8'hE7, "ff_wr");
      cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, "ff_rd");
      check_val("ff_val", bus_if.Bus_Out, 8'hE7);
      idle("ff_idle");

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            do_reset("rnd_rst");
         end else begin
            ale  = ($urandom_range(0, 4) == 0);
            en   = ($urandom_range(0, 1) == 1);
            rw   = ($urandom_range(0, 1) == 1);
            din  = ale ? addr_tab[$urandom_range(0, 6)] : 8'($urandom);
            lden = ($urandom_range(0, 3) == 0);
            la   = ($urandom_range(0, 1) == 1) ? m_addr : 8'($urandom);
            ld   = 8'($urandom);
            cycle(ale, en, rw, din, lden, la, ld, "rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameters (name, default, meaning):
- PROT_BOUND, 8'h80: first writable address when ROM_PROTECT_EN is defined.
- HOLD_CYCLES, 1: number of cycles Bus_Oe stays asserted after a read capture; legal range 1..3.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on posedge.
- rst, in, 1: reset; asynchronous and active-high.
- ALE, in, 1: address latch enable from the controller.
- En, in, 1: access strobe.
- Rw, in, 1: access direction; 1 = read, 0 = write.
- Bus_In, in, 8: address or data driven by the controller.
- Bus_Out, out, 8: read data to the controller.
- Bus_Oe, out, 1: Bus_Out valid/drive enable.
- Load_En, in, 1: side-port write strobe used for program preload.
- Load_Addr, in, 8: side-port address.
- Load_Data, in, 8: side-port data.
- Wr_Err, out, 1: protected-write pulse; tied 0 when ROM_PROTECT_EN is undefined.

Function
REQ-003 Storage SHALL be a 256x8 register array indexed by an 8-bit address; the array SHALL NOT be cleared by reset.
REQ-004 The FSM SHALL have three states: IDLE (no valid address), ADDR (address latched), DRIVE (read data on bus).
REQ-005 In any state, a posedge with ALE=1 SHALL load Addr_Reg<=Bus_In and set state ADDR.
REQ-006 When ALE=1, En in the same cycle SHALL be ignored: no read, no write.
REQ-007 In ADDR or DRIVE with ALE=0, En=1 and Rw=1, the posedge SHALL capture Rd_Reg<=mem[Addr_Reg], enter DRIVE, and load the hold counter with HOLD_CYCLES.
REQ-008 In ADDR or DRIVE with ALE=0, En=1 and Rw=0, the posedge SHALL write mem[Addr_Reg]<=Bus_In and enter ADDR.
REQ-009 Bus_Oe SHALL be high exactly while in DRIVE.
- Read latency: data is valid the cycle after the En&Rw cycle, which matches a controller loading its register at the end of that following cycle.
REQ-010 In DRIVE, the hold counter SHALL decrement each cycle with no new access; at 1 it SHALL return to ADDR, clearing Bus_Oe.
REQ-011 Bus_Out SHALL be Rd_Reg while Bus_Oe=1 and 8'h00 otherwise.
REQ-012 En=1 in IDLE SHALL be ignored; no drive and no write.
REQ-013 Addr_Reg SHALL NOT auto-increment; it SHALL stay valid until the next ALE, so back-to-back accesses hit the same address.
REQ-014 Load_En=1 SHALL write mem[Load_Addr]<=Load_Data at posedge regardless of state, with no FSM effect.
REQ-015 If a Load_En write and a bus write target the same address in the same cycle, the bus write SHALL win.
REQ-016 A read of an address written in the previous cycle SHALL return the new data; there is no bypass within the same cycle.
REQ-017 Address 8'hFF SHALL behave like any other address; there is no wrap logic.

Reset
REQ-018 rst=1 SHALL immediately force state IDLE, Addr_Reg=8'h00, Rd_Reg=8'h00, hold counter=0, Bus_Oe=0, Bus_Out=8'h00 and Wr_Err=0.
REQ-019 A reset during DRIVE SHALL drop Bus_Oe asynchronously; a bus write pending in the reset cycle SHALL NOT occur.
REQ-020 After rst is released, the first access SHALL require an ALE.

Configuration
REQ-021 Macro ROM_PROTECT_EN:
- Defined: bus writes with Addr_Reg < PROT_BOUND SHALL be discarded and Wr_Err SHALL pulse high for one cycle after the write cycle; Load_En writes SHALL be unaffected.
- Undefined: all addresses SHALL be writable and Wr_Err SHALL be constant 0.

Verification
REQ-022 Preload mem[0x10]=0xB3 via Load_En; ALE with Bus_In=0x10, then En=1/Rw=1 -> next cycle Bus_Oe=1 and Bus_Out=0xB3 for HOLD_CYCLES=1 cycle, then Bus_Oe=0.
REQ-023 ALE with 0x90 (Rw=0), then En=1/Rw=0 with Bus_In=0x5A, then En/Rw=1 -> Bus_Out=0x5A the following cycle.
REQ-024 ALE=1 and En=1 in the same cycle with Bus_In=0x20, then En=1/Rw=1 -> exactly one read of mem[0x20]; no read in the ALE cycle.
REQ-025 En=1/Rw=1 immediately after reset with no ALE -> Bus_Oe stays 0; then assert rst during DRIVE -> Bus_Oe=0 in the same cycle.
REQ-026 With ROM_PROTECT_EN defined: write 0x77 to 0x05 -> mem[0x05] unchanged and a one-cycle Wr_Err pulse; write to 0x80 succeeds with Wr_Err=0.
REQ-027 Same-cycle Load_En (addr 0x90, data 0x11) and bus write (0x90, 0x22) -> read of 0x90 returns 0x22.
